// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with field pre-decode and a gshare
// branch predictor (global history register XOR PC indexing a table of
// two-bit saturating counters). The history and counters are trained only
// at branch commit.
module fetch_stage #(
   parameter int          N        = 12,
   parameter logic [31:0] RESET_PC = 32'h80000000
) (
   input  logic          clk,
   input  logic          rst,
   output logic [31:0]   imem_addr,
   input  logic [31:0]   imem_rdata,
   input  logic          d_allow_in,
   output logic          f_to_d_valid,
   input  logic          e_valid,
   input  logic          e_is_jump_instr,
   input  logic          fact_success,
   input  logic [31:0]   e_fact_pc,
   input  logic          e_commit,
   input  logic [6:0]    E_opcode,
   input  logic [31:0]   E_pc,
   input  logic          e_fact_taken,
   input  logic [N-1:0]  E_pred_history,
   output logic [31:0]   F_pc,
   output logic [31:0]   f_instr,
   output logic [6:0]    f_opcode,
   output logic [4:0]    f_rd,
   output logic [9:0]    f_funct,
   output logic [4:0]    f_rs1,
   output logic [4:0]    f_rs2,
   output logic [31:0]   f_imm,
   output logic [2:0]    f_instr_type,
   output logic [31:0]   f_default_pc,
   output logic          f_is_jump_instr,
   output logic          f_pred_taken,
   output logic [N-1:0]  f_pred_history
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] TYPER = 3'd0;
   localparam logic [2:0] TYPEI = 3'd1;
   localparam logic [2:0] TYPES = 3'd2;
   localparam logic [2:0] TYPEB = 3'd3;
   localparam logic [2:0] TYPEU = 3'd4;
   localparam logic [2:0] TYPEJ = 3'd5;
   localparam logic [2:0] TYPEN = 3'd7;

   logic          f_valid;
   logic [N-1:0]  ghr;
   logic [1:0]    pht [1 << N];

   logic          redirect;
   logic [N-1:0]  pred_idx;
   logic [1:0]    pred_cnt;
   logic [31:0]   pred_pc;
   logic          train_en;
   logic [N-1:0]  train_idx;
   logic [1:0]    train_old;
   logic [1:0]    train_new;

   assign imem_addr      = F_pc;
   assign f_instr        = imem_rdata;
   assign f_opcode       = imem_rdata[6:0];
   assign f_funct        = {imem_rdata[31:25], imem_rdata[14:12]};
   assign f_default_pc   = F_pc + 32'd4;
   assign f_pred_history = ghr;

   assign redirect       = e_valid & e_is_jump_instr & ~fact_success;
   assign f_to_d_valid   = f_valid & ~redirect;

   assign pred_idx       = F_pc[N+1:2] ^ ghr;
   assign pred_cnt       = pht[pred_idx];

   assign train_en       = e_commit & (E_opcode == OP_BRANCH);
   assign train_idx      = E_pc[N+1:2] ^ E_pred_history;
   assign train_old      = pht[train_idx];

   // Classify the fetched opcode and extract register fields and immediate
   always_comb begin
      f_instr_type    = TYPEN;
      f_rd            = imem_rdata[11:7];
      f_rs1           = imem_rdata[19:15];
      f_rs2           = imem_rdata[24:20];
      f_imm           = 32'd0;
      f_is_jump_instr = 1'b0;
      case (f_opcode)
         OP_R: begin
            f_instr_type = TYPER;
         end
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
            f_instr_type    = TYPEI;
            f_rs2           = 5'd0;
            f_imm           = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
            f_is_jump_instr = (f_opcode == OP_JALR);
         end
         OP_STORE: begin
            f_instr_type = TYPES;
            f_rd         = 5'd0;
            f_imm        = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
         end
         OP_BRANCH: begin
            f_instr_type    = TYPEB;
            f_rd            = 5'd0;
            f_imm           = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                               imem_rdata[30:25], imem_rdata[11:8], 1'b0};
            f_is_jump_instr = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            f_instr_type = TYPEU;
            f_rs1        = 5'd0;
            f_rs2        = 5'd0;
            f_imm        = {imem_rdata[31:12], 12'd0};
         end
         OP_JAL: begin
            f_instr_type    = TYPEJ;
            f_rs1           = 5'd0;
            f_rs2           = 5'd0;
            f_imm           = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                               imem_rdata[20], imem_rdata[30:21], 1'b0};
            f_is_jump_instr = 1'b1;
         end
         default: begin
            f_instr_type = TYPEN;
         end
      endcase
   end

   // Predict direction and target: JAL always taken, branches follow the counter MSB
   always_comb begin
      f_pred_taken = (f_opcode == OP_JAL) | ((f_opcode == OP_BRANCH) & pred_cnt[1]);
      pred_pc      = f_pred_taken ? (F_pc + f_imm) : f_default_pc;
   end

   // Saturating increment or decrement of the counter being trained
   always_comb begin
      train_new = train_old;
      if (e_fact_taken) begin
         if (train_old != 2'b11) train_new = train_old + 2'd1;
      end else begin
         if (train_old != 2'b00) train_new = train_old - 2'd1;
      end
   end

   // Fetch PC and valid flag: redirect wins, otherwise advance when decode accepts
   always_ff @(posedge clk) begin
      if (rst) begin
         F_pc    <= RESET_PC;
         f_valid <= 1'b0;
      end else begin
         f_valid <= 1'b1;
         if (redirect) F_pc <= e_fact_pc;
         else if (d_allow_in & f_to_d_valid) F_pc <= pred_pc;
      end
   end

   // Global history shifts in the resolved outcome of each committed branch
   always_ff @(posedge clk) begin
      if (rst) ghr <= '0;
      else if (train_en) ghr <= {ghr[N-2:0], e_fact_taken};
   end

   // Pattern table: all counters weakly not-taken after reset, trained at commit
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < (1 << N); i++) pht[i[N-1:0]] <= 2'b01;
      end else if (train_en) begin
         pht[train_idx] <= train_new;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. Expected values are queued
// as each step is driven and drained against the DUT outputs afterwards.
module tb_fetch_stage;

   localparam int N = 12;

   localparam logic [2:0] TYPEI = 3'd1;
   localparam logic [2:0] TYPES = 3'd2;
   localparam logic [2:0] TYPEB = 3'd3;
   localparam logic [2:0] TYPEU = 3'd4;
   localparam logic [2:0] TYPEJ = 3'd5;

   localparam logic [31:0] ADDI = 32'h00100093;
   localparam logic [31:0] JAL  = 32'h0100006F;
   localparam logic [31:0] BEQ  = 32'h00000463;
   localparam logic [31:0] LUI  = 32'h123450B7;
   localparam logic [31:0] SW   = 32'hFE20AE23;
   localparam logic [31:0] JALR = 32'h000080E7;

   logic          clk;
   logic          rst;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          d_allow_in;
   logic          f_to_d_valid;
   logic          e_valid;
   logic          e_is_jump_instr;
   logic          fact_success;
   logic [31:0]   e_fact_pc;
   logic          e_commit;
   logic [6:0]    E_opcode;
   logic [31:0]   E_pc;
   logic          e_fact_taken;
   logic [N-1:0]  E_pred_history;
   logic [31:0]   F_pc;
   logic [31:0]   f_instr;
   logic [6:0]    f_opcode;
   logic [4:0]    f_rd;
   logic [9:0]    f_funct;
   logic [4:0]    f_rs1;
   logic [4:0]    f_rs2;
   logic [31:0]   f_imm;
   logic [2:0]    f_instr_type;
   logic [31:0]   f_default_pc;
   logic          f_is_jump_instr;
   logic          f_pred_taken;
   logic [N-1:0]  f_pred_history;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t scoreboard[$];
   int   assertCount = 0;
   int   failCount   = 0;
   logic [31:0] modelPc;

   fetch_stage #(.N(N), .RESET_PC(32'h80000000)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .d_allow_in(d_allow_in), .f_to_d_valid(f_to_d_valid), .e_valid(e_valid),
      .e_is_jump_instr(e_is_jump_instr), .fact_success(fact_success),
      .e_fact_pc(e_fact_pc), .e_commit(e_commit), .E_opcode(E_opcode), .E_pc(E_pc),
      .e_fact_taken(e_fact_taken), .E_pred_history(E_pred_history), .F_pc(F_pc),
      .f_instr(f_instr), .f_opcode(f_opcode), .f_rd(f_rd), .f_funct(f_funct),
      .f_rs1(f_rs1), .f_rs2(f_rs2), .f_imm(f_imm), .f_instr_type(f_instr_type),
      .f_default_pc(f_default_pc), .f_is_jump_instr(f_is_jump_instr),
      .f_pred_taken(f_pred_taken), .f_pred_history(f_pred_history)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] observe(string tag);
      case (tag)
         "pc":    return F_pc;
         "addr":  return imem_addr;
         "valid": return {31'd0, f_to_d_valid};
         "rd":    return {27'd0, f_rd};
         "rs1":   return {27'd0, f_rs1};
         "rs2":   return {27'd0, f_rs2};
         "imm":   return f_imm;
         "type":  return {29'd0, f_instr_type};
         "dflt":  return f_default_pc;
         "jump":  return {31'd0, f_is_jump_instr};
         "taken": return {31'd0, f_pred_taken};
         "hist":  return {20'd0, f_pred_history};
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   task automatic expectOut(string tag, logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      scoreboard.push_back(e);
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput();
      exp_t e;
      logic [31:0] obs;
      #1;
      while (scoreboard.size() > 0) begin
         e   = scoreboard.pop_front();
         obs = observe(e.tag);
         assertCount++;
         assert (obs === e.exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic expectAddi();
      expectOut("rd", 32'd1);
      expectOut("rs1", 32'd0);
      expectOut("rs2", 32'd0);
      expectOut("imm", 32'd1);
      expectOut("type", {29'd0, TYPEI});
      expectOut("dflt", modelPc + 32'd4);
      expectOut("jump", 32'd0);
      expectOut("taken", 32'd0);
   endtask

   // Directed sequence covering reset, streaming, prediction, stall, redirect and training
   initial begin
      rst = 1'b1; imem_rdata = ADDI; d_allow_in = 1'b1;
      e_valid = 1'b0; e_is_jump_instr = 1'b0; fact_success = 1'b0; e_fact_pc = '0;
      e_commit = 1'b0; E_opcode = '0; E_pc = '0; e_fact_taken = 1'b0; E_pred_history = '0;
      modelPc = 32'h80000000;

      applyStimulus();
      applyStimulus();
      expectOut("pc", modelPc);
      expectOut("valid", 32'd0);
      expectOut("hist", 32'd0);
      checkOutput();

      rst = 1'b0;
      expectOut("pc", modelPc);
      expectOut("valid", 32'd0);
      checkOutput();

      applyStimulus();
      expectOut("pc", modelPc);
      expectOut("addr", modelPc);
      expectOut("valid", 32'd1);
      expectAddi();
      checkOutput();

      for (int k = 0; k < 2; k++) begin
         applyStimulus();
         modelPc = modelPc + 32'd4;
         expectOut("pc", modelPc);
         expectAddi();
         checkOutput();
      end

      imem_rdata = JAL;
      expectOut("taken", 32'd1);
      expectOut("jump", 32'd1);
      expectOut("rd", 32'd0);
      expectOut("imm", 32'd16);
      expectOut("type", {29'd0, TYPEJ});
      checkOutput();
      applyStimulus();
      modelPc = 32'h80000018;
      expectOut("pc", modelPc);
      checkOutput();

      imem_rdata = LUI;
      expectOut("imm", 32'h12345000);
      expectOut("type", {29'd0, TYPEU});
      expectOut("rs1", 32'd0);
      expectOut("rs2", 32'd0);
      expectOut("rd", 32'd1);
      checkOutput();

      imem_rdata = SW;
      expectOut("imm", 32'hFFFFFFFC);
      expectOut("type", {29'd0, TYPES});
      expectOut("rd", 32'd0);
      expectOut("rs1", 32'd1);
      expectOut("rs2", 32'd2);
      checkOutput();

      imem_rdata = JALR;
      expectOut("jump", 32'd1);
      expectOut("taken", 32'd0);
      expectOut("type", {29'd0, TYPEI});
      checkOutput();

      imem_rdata = ADDI;
      d_allow_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         expectOut("pc", modelPc);
         expectOut("valid", 32'd1);
         expectAddi();
         checkOutput();
      end
      d_allow_in = 1'b1;
      applyStimulus();
      modelPc = modelPc + 32'd4;
      expectOut("pc", modelPc);
      checkOutput();

      e_valid = 1'b1; e_is_jump_instr = 1'b1; fact_success = 1'b0; e_fact_pc = 32'h80000100;
      expectOut("valid", 32'd0);
      checkOutput();
      applyStimulus();
      e_valid = 1'b0; e_is_jump_instr = 1'b0;
      modelPc = 32'h80000100;
      expectOut("pc", modelPc);
      expectOut("valid", 32'd1);
      checkOutput();

      rst = 1'b1;
      e_valid = 1'b1; e_is_jump_instr = 1'b1; e_fact_pc = 32'h80000200;
      e_commit = 1'b1; E_opcode = 7'b1100011; E_pc = 32'h80000020; e_fact_taken = 1'b1;
      applyStimulus();
      modelPc = 32'h80000000;
      expectOut("pc", modelPc);
      expectOut("hist", 32'd0);
      checkOutput();
      e_valid = 1'b0; e_is_jump_instr = 1'b0; e_commit = 1'b0;
      applyStimulus();
      rst = 1'b0;

      e_commit = 1'b1; E_opcode = 7'b1100011; E_pc = 32'h80000020;
      E_pred_history = '0; e_fact_taken = 1'b1;
      applyStimulus();
      e_commit = 1'b0;
      expectOut("hist", 32'd1);
      expectOut("pc", modelPc);
      expectOut("valid", 32'd1);
      checkOutput();

      e_valid = 1'b1; e_is_jump_instr = 1'b1; fact_success = 1'b0; e_fact_pc = 32'h80000024;
      applyStimulus();
      e_valid = 1'b0; e_is_jump_instr = 1'b0;
      imem_rdata = BEQ;
      modelPc = 32'h80000024;
      expectOut("pc", modelPc);
      expectOut("taken", 32'd1);
      expectOut("type", {29'd0, TYPEB});
      expectOut("imm", 32'd8);
      expectOut("rd", 32'd0);
      expectOut("hist", 32'd1);
      checkOutput();

      applyStimulus();
      modelPc = 32'h8000002C;
      expectOut("pc", modelPc);
      expectOut("taken", 32'd0);
      checkOutput();
      applyStimulus();
      modelPc = 32'h80000030;
      expectOut("pc", modelPc);
      checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage RV32I pipeline, feeding the decode stage. Holds the fetch PC, reads instruction memory combinationally, and pre-decodes fields and immediate. Predicts next PC with a gshare predictor (N-bit global history, 2^N two-bit counters) trained at branch commit. Redirects on execute-stage mispredict.

## Interface
- N, 12, global history width; PHT has 2^N entries
- RESET_PC, 32'h80000000, first fetch address
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  = F_pc
- imem_rdata  in  32  instruction at imem_addr, same cycle
- d_allow_in  in  1  decode can accept
- f_to_d_valid  out  1  F slot holds a valid, non-killed instruction
- e_valid  in  1  E slot valid
- e_is_jump_instr  in  1  E holds branch/JAL/JALR
- fact_success  in  1  E prediction was correct
- e_fact_pc  in  32  correct next PC of E instruction
- e_commit  in  1  E instruction leaves E this cycle (one pulse per instruction)
- E_opcode  in  7  E opcode
- E_pc  in  32  E instruction PC
- e_fact_taken  in  1  E branch resolved taken
- E_pred_history  in  N  history captured when E instruction was fetched
- F_pc  out  32  fetch PC register
- f_instr  out  32  = imem_rdata
- f_opcode  out  7  instr[6:0]
- f_rd  out  5  instr[11:7]; 0 for S/B
- f_funct  out  10  {instr[31:25], instr[14:12]}
- f_rs1  out  5  instr[19:15]; 0 for U/J
- f_rs2  out  5  instr[24:20]; 0 for I/U/J
- f_imm  out  32  sign-extended immediate per type; 0 for R
- f_instr_type  out  3  `TYPER/I/S/B/U/J; `TYPEN (define.v) for unknown opcode
- f_default_pc  out  32  F_pc + 4
- f_is_jump_instr  out  1  opcode is OP_BRANCH, OP_JAL or OP_JALR
- f_pred_taken  out  1  predicted taken
- f_pred_history  out  N  current GHR

## Operation
- Type map: OP_R→R; OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM→I; OP_STORE→S; OP_BRANCH→B; OP_LUI, OP_AUIPC→U; OP_JAL→J.
- Immediates: U = {instr[31:12],12'b0}; B/J bit-0 = 0; all others sign-extended from instr[31].
- PHT index = F_pc[N+1:2] ^ GHR. Counters 00..11; taken prediction = counter[1].
- Prediction: JAL taken, target F_pc+f_imm; BRANCH taken iff counter[1], target F_pc+f_imm; JALR and others not taken, next PC f_default_pc.
- redirect = e_valid & e_is_jump_instr & ~fact_success.
- f_to_d_valid = f_valid & ~redirect.
- F_pc next: redirect → e_fact_pc; else d_allow_in & f_to_d_valid → predicted PC; else hold.
- f_valid: 0 in reset, 1 from first cycle after reset, stays 1.
- Training on e_commit & (E_opcode==OP_BRANCH): PHT[E_pc[N+1:2]^E_pred_history] saturating +1 if e_fact_taken else −1; GHR <= {GHR[N-2:0], e_fact_taken}. GHR non-speculative; changes only here.
- PC arithmetic modulo 2^32, wraps silently.

## Timing
- Reset: F_pc=RESET_PC, f_valid=0, GHR=0, all PHT=01. Outputs then follow F_pc/imem_rdata combinationally.
- First cycle after reset: f_to_d_valid=0; second cycle: 1 with F_pc=RESET_PC.
- Throughput one instruction/cycle while d_allow_in=1; zero-latency imem.
- Stall (d_allow_in=0): F_pc, GHR held; outputs stable.
- Redirect beats d_allow_in; repeated redirect while E stalls rewrites same PC, harmless.
- PHT write and fetch read of same index in same cycle: read sees old value (no bypass).
- Training and redirect in same cycle both take effect.
- rst mid-operation overrides all, including pending redirect/training.

## Test plan
- rst high 2 cycles, imem_rdata=0x00100093 → cycle 1 after release f_to_d_valid=0, F_pc=0x80000000; cycle 2 valid=1.
- Stream 0x00100093 (addi x1,x0,1), d_allow_in=1 → F_pc +4 per cycle; f_rd=1, f_rs1=0, f_rs2=0, f_imm=1, TYPEI, f_default_pc=F_pc+4.
- 0x0100006F (jal x0,16) at 0x80000008 → f_pred_taken=1, next F_pc=0x80000018, f_is_jump_instr=1, f_rd=0.
- d_allow_in=0 for 3 cycles → F_pc and all f_* unchanged; release → resumes +4.
- redirect with e_fact_pc=0x80000100, d_allow_in=1 → f_to_d_valid=0 that cycle; next F_pc=0x80000100.
- After reset, e_commit OP_BRANCH, E_pc=0x80000020, E_pred_history=0, e_fact_taken=1 → PHT[8]=10, GHR=1; then 0x00000463 (beq x0,x0,8) fetched at 0x80000024 → f_pred_taken=1, next F_pc=0x8000002C.
